// File: rtl/sga_snake_body.sv
// sga_snake_body
// Snake body datapath for the Snake Game Arcade. Holds the segment
// coordinates (seg[0] is the head), the latched player direction and the
// current length. Each move strobe advances the head one cell. The
// apple/border/body flags are registered so the control unit can sample
// them in the cycle after the move. A render index walks the segments one
// by one for the display.
//
// Strobe semantics: init, register_dir, move, grow, render_clr and
// render_count are single-cycle command strobes. They carry no handshake.
// Each is acted on at the rising edge where it is high, and is applied
// again on every further edge where it stays high.
// Command priority is restart_n > init > {move, grow, register_dir}.
// A move always uses the direction latched before its edge.

module sga_snake_body #(
  parameter int W        = 4,
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 3
) (
  input  logic                           clock,
  input  logic                           restart_n,
  input  logic                           init,
  input  logic [1:0]                     dir_in,
  input  logic                           register_dir,
  input  logic                           move,
  input  logic                           grow,
  input  logic [W-1:0]                   apple_x,
  input  logic [W-1:0]                   apple_y,
  input  logic                           render_clr,
  input  logic                           render_count,
  output logic [W-1:0]                   render_x,
  output logic [W-1:0]                   render_y,
  output logic                           render_finish,
  output logic                           is_at_apple,
  output logic                           is_at_border,
  output logic                           is_at_body,
  output logic [$clog2(MAX_LEN+1)-1:0]   length,
  output logic                           full
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [W-1:0]  MID        = W'(2 ** (W - 1));
  localparam logic [LW-1:0] INIT_LEN_L = LW'(INIT_LEN);
  localparam logic [LW-1:0] MAX_LEN_L  = LW'(MAX_LEN);
  localparam logic [IW-1:0] LAST_IDX   = IW'(MAX_LEN - 1);

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  // Initial snake: horizontal, head at the grid centre, facing right.
  // Entries past the initial tail repeat the tail. A later grow then
  // exposes a valid cell.
  function automatic logic [W-1:0] init_x(input int i);
    int k;
    k = (i < INIT_LEN) ? i : INIT_LEN - 1;
    return MID - W'(k);
  endfunction

  // State
  logic [W-1:0]  r_seg_x [MAX_LEN];
  logic [W-1:0]  r_seg_y [MAX_LEN];
  logic [LW-1:0] r_len;
  logic [1:0]    r_dir;
  logic [IW-1:0] r_idx;
  logic          r_apple;
  logic          r_border;
  logic          r_body;

  // Next-head datapath
  logic [W:0]    w_nh_x_ext;
  logic [W:0]    w_nh_y_ext;
  logic [W-1:0]  w_nh_x;
  logic [W-1:0]  w_nh_y;
  logic          w_leave;
  logic          w_body_hit;
  logic          w_apple_hit;
  logic          w_do_shift;
  logic          w_reload;
  logic          w_dir_ok;

  assign w_reload = ~restart_n | init;

  // Candidate head one cell along the latched direction.
  // The computation is one bit wider than the grid, so the carry or
  // borrow in bit W flags an attempt to leave the grid.
  always_comb begin
    w_nh_x_ext = {1'b0, r_seg_x[0]};
    w_nh_y_ext = {1'b0, r_seg_y[0]};
    case (r_dir)
      DIR_UP:    w_nh_y_ext = {1'b0, r_seg_y[0]} - (W+1)'(1);
      DIR_RIGHT: w_nh_x_ext = {1'b0, r_seg_x[0]} + (W+1)'(1);
      DIR_DOWN:  w_nh_y_ext = {1'b0, r_seg_y[0]} + (W+1)'(1);
      DIR_LEFT:  w_nh_x_ext = {1'b0, r_seg_x[0]} - (W+1)'(1);
      default:   w_nh_x_ext = {1'b0, r_seg_x[0]};
    endcase
  end

  assign w_nh_x      = w_nh_x_ext[W-1:0];
  assign w_nh_y      = w_nh_y_ext[W-1:0];
  assign w_leave     = w_nh_x_ext[W] | w_nh_y_ext[W];
  assign w_apple_hit = (w_nh_x == apple_x) && (w_nh_y == apple_y);
  assign w_do_shift  = move & ~w_leave;

  // A 180-degree reversal differs from the current direction in bit 1 only.
  assign w_dir_ok = ((dir_in ^ r_dir) != 2'b10);

  // Self-collision: compare the candidate head with body cells 1..length-2.
  // The current tail (index length-1) is excluded because it moves away
  // on this same step.
  always_comb begin
    w_body_hit = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if ((i < int'(r_len) - 1) && (r_seg_x[i] == w_nh_x) && (r_seg_y[i] == w_nh_y)) begin
        w_body_hit = 1'b1;
      end
    end
  end

  // Segment array: reload the initial snake, or shift toward the tail
  // and insert the new head. Cells past length are shifted as well.
  // This keeps the old tail in seg[length] so that a grow can expose it.
  always_ff @(posedge clock) begin
    if (w_reload) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        r_seg_x[i] <= init_x(i);
        r_seg_y[i] <= MID;
      end
    end else if (w_do_shift) begin
      r_seg_x[0] <= w_nh_x;
      r_seg_y[0] <= w_nh_y;
      for (int i = 1; i < MAX_LEN; i++) begin
        r_seg_x[i] <= r_seg_x[i-1];
        r_seg_y[i] <= r_seg_y[i-1];
      end
    end
  end

  // Direction latch: a reversal request is ignored.
  always_ff @(posedge clock) begin
    if (w_reload) begin
      r_dir <= DIR_RIGHT;
    end else if (register_dir && w_dir_ok) begin
      r_dir <= dir_in;
    end
  end

  // Outcome flags: written only by a move, and held until the next move or reload.
  always_ff @(posedge clock) begin
    if (w_reload) begin
      r_apple  <= 1'b0;
      r_border <= 1'b0;
      r_body   <= 1'b0;
    end else if (move) begin
      if (w_leave) begin
        r_apple  <= 1'b0;
        r_border <= 1'b1;
        r_body   <= 1'b0;
      end else begin
        r_apple  <= w_apple_hit;
        r_border <= 1'b0;
        r_body   <= w_body_hit;
      end
    end
  end

  // Length: saturating grow. A border-blocked move freezes the body, and
  // the length is frozen with it.
  always_ff @(posedge clock) begin
    if (w_reload) begin
      r_len <= INIT_LEN_L;
    end else if (grow && !(move && w_leave) && (r_len != MAX_LEN_L)) begin
      r_len <= r_len + 1'b1;
    end
  end

  // Render index: a clear beats a count, and a count saturates at the last array slot.
  always_ff @(posedge clock) begin
    if (w_reload) begin
      r_idx <= '0;
    end else if (render_clr) begin
      r_idx <= '0;
    end else if (render_count && (r_idx != LAST_IDX)) begin
      r_idx <= r_idx + 1'b1;
    end
  end

  assign render_x      = r_seg_x[r_idx];
  assign render_y      = r_seg_y[r_idx];
  assign render_finish = (LW'(r_idx) == (r_len - LW'(1)));
  assign is_at_apple   = r_apple;
  assign is_at_border  = r_border;
  assign is_at_body    = r_body;
  assign length        = r_len;
  assign full          = (r_len == MAX_LEN_L);

endmodule

// File: tb/tb_sga_snake_body.sv
// tb_sga_snake_body
// Directed table and hand-written sequences with constant expectations.
// These are followed by a randomized phase checked against a queue-based
// snake model.

module tb_sga_snake_body;

  localparam int W        = 4;
  localparam int MAX_LEN  = 16;
  localparam int INIT_LEN = 3;
  localparam int LW       = 5;
  localparam int OW       = 2 * W + 4 + LW + 1;

  // ---------------- clock / reset / DUT ----------------
  logic          clock = 1'b0;
  logic          restart_n;
  logic          init;
  logic [1:0]    dir_in;
  logic          register_dir;
  logic          move;
  logic          grow;
  logic [W-1:0]  apple_x;
  logic [W-1:0]  apple_y;
  logic          render_clr;
  logic          render_count;
  logic [W-1:0]  render_x;
  logic [W-1:0]  render_y;
  logic          render_finish;
  logic          is_at_apple;
  logic          is_at_border;
  logic          is_at_body;
  logic [LW-1:0] length;
  logic          full;

  always #5 clock = ~clock;

  sga_snake_body #(.W(W), .MAX_LEN(MAX_LEN), .INIT_LEN(INIT_LEN)) dut (
    .clock(clock), .restart_n(restart_n), .init(init), .dir_in(dir_in),
    .register_dir(register_dir), .move(move), .grow(grow),
    .apple_x(apple_x), .apple_y(apple_y),
    .render_clr(render_clr), .render_count(render_count),
    .render_x(render_x), .render_y(render_y), .render_finish(render_finish),
    .is_at_apple(is_at_apple), .is_at_border(is_at_border), .is_at_body(is_at_body),
    .length(length), .full(full)
  );

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input bit ini, input bit rd, input logic [1:0] din,
                       input bit mv, input bit gr, input bit rc, input bit rcnt);
    init = ini; register_dir = rd; dir_in = din; move = mv; grow = gr;
    render_clr = rc; render_count = rcnt;
    tick();
    init = 0; register_dir = 0; move = 0; grow = 0; render_clr = 0; render_count = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_cell(input string name, input int x, input int y);
    chk({name, ".x"}, 32'(render_x), 32'(x));
    chk({name, ".y"}, 32'(render_y), 32'(y));
  endtask

  task automatic chk_flags(input string name, input bit ap, input bit bd, input bit by);
    chk({name, ".apple"},  32'(is_at_apple),  32'(ap));
    chk({name, ".border"}, 32'(is_at_border), 32'(bd));
    chk({name, ".body"},   32'(is_at_body),   32'(by));
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    string      name;
    bit         ini;
    bit         rd;
    logic [1:0] din;
    bit         mv;
    bit         gr;
    int         ax;
    int         ay;
    int         hx;
    int         hy;
    int         len;
    bit         ap;
    bit         bd;
    bit         by;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mk(input string n, input bit ini, input bit rd, input logic [1:0] din,
                              input bit mv, input bit gr, input int ax, input int ay,
                              input int hx, input int hy, input int len,
                              input bit ap, input bit bd, input bit by);
    vec_t v;
    v.name = n; v.ini = ini; v.rd = rd; v.din = din; v.mv = mv; v.gr = gr;
    v.ax = ax; v.ay = ay; v.hx = hx; v.hy = hy; v.len = len;
    v.ap = ap; v.bd = bd; v.by = by;
    return v;
  endfunction

  // ---------------- reference model (queue of cells) ----------------
  typedef struct { int x; int y; } pt_t;
  pt_t  mq[$];
  int   m_len;
  int   m_dir;
  int   m_idx;
  bit   m_ap;
  bit   m_bd;
  bit   m_by;
  logic [OW-1:0] exp_q[$];

  function automatic void m_reset();
    pt_t p;
    mq.delete();
    for (int i = 0; i < MAX_LEN; i++) begin
      p.x = (MAX_LEN > 0) ? (8 - ((i < INIT_LEN) ? i : INIT_LEN - 1)) : 0;
      p.y = 8;
      mq.push_back(p);
    end
    m_len = INIT_LEN; m_dir = 1; m_idx = 0;
    m_ap = 0; m_bd = 0; m_by = 0;
  endfunction

  function automatic void m_clock(input bit rn, input bit ini, input bit rd, input int din,
                                  input bit mv, input bit gr, input bit rc, input bit rcnt,
                                  input int ax, input int ay);
    pt_t nh;
    bit  blocked;
    blocked = 0;
    if (!rn || ini) begin
      m_reset();
      return;
    end
    if (mv) begin
      nh = mq[0];
      case (m_dir)
        0: nh.y = nh.y - 1;
        1: nh.x = nh.x + 1;
        2: nh.y = nh.y + 1;
        default: nh.x = nh.x - 1;
      endcase
      if (nh.x < 0 || nh.x > 15 || nh.y < 0 || nh.y > 15) begin
        blocked = 1;
        m_bd = 1; m_ap = 0; m_by = 0;
      end else begin
        m_by = 0;
        for (int i = 1; i < m_len - 1; i++)
          if (mq[i].x == nh.x && mq[i].y == nh.y) m_by = 1;
        m_ap = (nh.x == ax) && (nh.y == ay);
        m_bd = 0;
        mq.push_front(nh);
        void'(mq.pop_back());
      end
    end
    if (gr && !blocked && m_len < MAX_LEN) m_len++;
    if (rd && ((din ^ m_dir) != 2)) m_dir = din;
    if (rc) m_idx = 0;
    else if (rcnt && m_idx < MAX_LEN - 1) m_idx++;
  endfunction

  function automatic logic [OW-1:0] m_expect();
    logic [W-1:0]  ex;
    logic [W-1:0]  ey;
    logic [LW-1:0] el;
    ex = W'(mq[m_idx].x);
    ey = W'(mq[m_idx].y);
    el = LW'(m_len);
    return {ex, ey, (m_idx == m_len - 1), m_ap, m_bd, m_by, el, (m_len == MAX_LEN)};
  endfunction

  // ---------------- main test ----------------
  initial begin
    logic [OW-1:0] dut_w;
    logic [OW-1:0] exp_w;
    bit  r_rn, r_ini, r_rd, r_mv, r_gr, r_rc, r_rcnt;
    int  r_din, r_ax, r_ay;

    restart_n = 0; init = 0; dir_in = 0; register_dir = 0; move = 0; grow = 0;
    apple_x = 0; apple_y = 0; render_clr = 0; render_count = 0;
    tick(); tick();

    // Reset state
    chk("rst.len", 32'(length), 3);
    chk("rst.full", 32'(full), 0);
    chk("rst.finish", 32'(render_finish), 0);
    chk_cell("rst.head", 8, 8);
    chk_flags("rst", 0, 0, 0);
    restart_n = 1;

    // Render walk across the initial snake
    drive(0, 0, 0, 0, 0, 1, 0);
    chk_cell("walk0", 8, 8); chk("walk0.fin", 32'(render_finish), 0);
    drive(0, 0, 0, 0, 0, 0, 1);
    chk_cell("walk1", 7, 8); chk("walk1.fin", 32'(render_finish), 0);
    drive(0, 0, 0, 0, 0, 0, 1);
    chk_cell("walk2", 6, 8); chk("walk2.fin", 32'(render_finish), 1);
    chk("walk.len", 32'(length), 3);
    for (int i = 0; i < 20; i++) drive(0, 0, 0, 0, 0, 0, 1);
    chk_cell("walk_sat", 6, 8); chk("walk_sat.fin", 32'(render_finish), 0);
    drive(0, 0, 0, 0, 0, 1, 1);
    chk_cell("clr_prio", 8, 8);

    // Directed table; each step also clears the render index so render_x/y show the head
    tbl[0]  = mk("idle",        0, 0, 2'd0, 0, 0, 0, 0,  8, 8, 3, 0, 0, 0);
    tbl[1]  = mk("reg_down",    0, 1, 2'd2, 0, 0, 0, 0,  8, 8, 3, 0, 0, 0);
    tbl[2]  = mk("move_down",   0, 0, 2'd0, 1, 0, 0, 0,  8, 9, 3, 0, 0, 0);
    tbl[3]  = mk("init",        1, 0, 2'd0, 0, 0, 0, 0,  8, 8, 3, 0, 0, 0);
    tbl[4]  = mk("rev_ignored", 0, 1, 2'd3, 0, 0, 0, 0,  8, 8, 3, 0, 0, 0);
    tbl[5]  = mk("move_apple",  0, 0, 2'd0, 1, 0, 9, 8,  9, 8, 3, 1, 0, 0);
    tbl[6]  = mk("grow",        0, 0, 2'd0, 0, 1, 9, 8,  9, 8, 4, 1, 0, 0);
    tbl[7]  = mk("move_grow",   0, 0, 2'd0, 1, 1, 9, 8, 10, 8, 5, 0, 0, 0);
    tbl[8]  = mk("mv11",        0, 0, 2'd0, 1, 0, 0, 0, 11, 8, 5, 0, 0, 0);
    tbl[9]  = mk("mv12",        0, 0, 2'd0, 1, 0, 0, 0, 12, 8, 5, 0, 0, 0);
    tbl[10] = mk("mv13",        0, 0, 2'd0, 1, 0, 0, 0, 13, 8, 5, 0, 0, 0);
    tbl[11] = mk("mv14",        0, 0, 2'd0, 1, 0, 0, 0, 14, 8, 5, 0, 0, 0);
    tbl[12] = mk("mv15",        0, 0, 2'd0, 1, 0, 0, 0, 15, 8, 5, 0, 0, 0);
    tbl[13] = mk("border",      0, 0, 2'd0, 1, 0, 0, 0, 15, 8, 5, 0, 1, 0);
    tbl[14] = mk("border_hold", 0, 0, 2'd0, 0, 0, 0, 0, 15, 8, 5, 0, 1, 0);
    tbl[15] = mk("reg_up",      0, 1, 2'd0, 0, 0, 0, 0, 15, 8, 5, 0, 1, 0);
    tbl[16] = mk("move_up",     0, 0, 2'd0, 1, 0, 0, 0, 15, 7, 5, 0, 0, 0);
    tbl[17] = mk("init_cancel", 1, 0, 2'd0, 1, 0, 0, 0,  8, 8, 3, 0, 0, 0);
    for (int k = 0; k < 18; k++) begin
      apple_x = W'(tbl[k].ax);
      apple_y = W'(tbl[k].ay);
      drive(tbl[k].ini, tbl[k].rd, tbl[k].din, tbl[k].mv, tbl[k].gr, 1, 0);
      chk_cell(tbl[k].name, tbl[k].hx, tbl[k].hy);
      chk({tbl[k].name, ".len"}, 32'(length), 32'(tbl[k].len));
      chk({tbl[k].name, ".full"}, 32'(full), 0);
      chk_flags(tbl[k].name, tbl[k].ap, tbl[k].bd, tbl[k].by);
    end
    apple_x = 0; apple_y = 0;

    // Shift after a down move: seg[1]=(8,8), seg[2]=(7,8)
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 2'd2, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 1, 0);
    chk_cell("down.seg0", 8, 9);
    drive(0, 0, 0, 0, 0, 0, 1);
    chk_cell("down.seg1", 8, 8);
    drive(0, 0, 0, 0, 0, 0, 1);
    chk_cell("down.seg2", 7, 8);
    chk_flags("down", 0, 0, 0);

    // Apple then grow exposes the old tail
    drive(1, 0, 0, 0, 0, 0, 0);
    apple_x = 9; apple_y = 8;
    drive(0, 0, 0, 1, 0, 1, 0);
    chk_flags("eat", 1, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    chk("eat.len", 32'(length), 4);
    drive(0, 0, 0, 0, 0, 0, 1); drive(0, 0, 0, 0, 0, 0, 1); drive(0, 0, 0, 0, 0, 0, 1);
    chk_cell("eat.tail", 6, 8);
    chk("eat.fin", 32'(render_finish), 1);
    apple_x = 0; apple_y = 0;

    // Length 5 loop: up into seg[3] is a body hit
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0);
    drive(0, 1, 2'd2, 0, 0, 0, 0); drive(0, 0, 0, 1, 0, 0, 0);
    drive(0, 1, 2'd3, 0, 0, 0, 0); drive(0, 0, 0, 1, 0, 0, 0);
    chk_flags("loop5.pre", 0, 0, 0);
    drive(0, 1, 2'd0, 0, 0, 0, 0); drive(0, 0, 0, 1, 0, 1, 0);
    chk_flags("loop5.hit", 0, 0, 1);
    chk_cell("loop5.head", 8, 8);

    // Length 4 loop: up into the vacating tail is not a hit
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0);
    drive(0, 1, 2'd2, 0, 0, 0, 0); drive(0, 0, 0, 1, 0, 0, 0);
    drive(0, 1, 2'd3, 0, 0, 0, 0); drive(0, 0, 0, 1, 0, 0, 0);
    drive(0, 1, 2'd0, 0, 0, 0, 0); drive(0, 0, 0, 1, 0, 1, 0);
    chk_flags("loop4.tail", 0, 0, 0);
    chk_cell("loop4.head", 8, 8);

    // Saturating grow, then init and reset mid-game
    drive(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) drive(0, 0, 0, 0, 1, 0, 0);
    chk("sat.len", 32'(length), 16);
    chk("sat.full", 32'(full), 1);
    apple_x = 9; apple_y = 8;
    drive(0, 0, 0, 1, 0, 0, 0);
    chk_flags("sat.eat", 1, 0, 0);
    chk("sat.len2", 32'(length), 16);
    drive(1, 0, 0, 0, 0, 0, 0);
    chk("reinit.len", 32'(length), 3);
    chk("reinit.full", 32'(full), 0);
    chk_flags("reinit", 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0);
    chk_flags("pre_rst", 1, 0, 0);
    restart_n = 0;
    drive(0, 0, 0, 1, 1, 0, 1);
    restart_n = 1;
    chk_flags("midrst", 0, 0, 0);
    chk("midrst.len", 32'(length), 3);
    chk_cell("midrst.head", 8, 8);

    // Randomized phase against the model
    restart_n = 0; tick(); restart_n = 1;
    m_reset();
    for (int c = 0; c < 800; c++) begin
      r_rn   = ($urandom_range(0, 99) != 0);
      r_ini  = ($urandom_range(0, 39) == 0);
      r_rd   = ($urandom_range(0, 2) == 0);
      r_din  = $urandom_range(0, 3);
      r_mv   = $urandom_range(0, 1) == 1;
      r_gr   = !r_mv && ($urandom_range(0, 3) == 0);
      r_rc   = ($urandom_range(0, 7) == 0);
      r_rcnt = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 2) == 0) begin
        r_ax = (mq[0].x + $urandom_range(0, 2) - 1) & 15;
        r_ay = (mq[0].y + $urandom_range(0, 2) - 1) & 15;
      end else begin
        r_ax = $urandom_range(0, 15);
        r_ay = $urandom_range(0, 15);
      end
      apple_x = W'(r_ax); apple_y = W'(r_ay);
      restart_n = r_rn;
      m_clock(r_rn, r_ini, r_rd, r_din, r_mv, r_gr, r_rc, r_rcnt, r_ax, r_ay);
      exp_q.push_back(m_expect());
      drive(r_ini, r_rd, 2'(r_din), r_mv, r_gr, r_rc, r_rcnt);
      restart_n = 1;
      dut_w = {render_x, render_y, render_finish, is_at_apple, is_at_border, is_at_body, length, full};
      exp_w = exp_q.pop_front();
      n_checks++;
      if (dut_w !== exp_w) begin
        n_errors++;
        $display("FAIL rand[%0d]: got %h expected %h (x,y,fin,ap,bd,by,len,full)", c, dut_w, exp_w);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
